// File: rtl/memory_arbiter_pkg.sv
// Shared types and counter sizing for the memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} grant_t;

  localparam int DEF_STARVE_LIMIT   = 4;
  localparam int DEF_TIMEOUT_CYCLES = 15;

  // Bits needed to hold the values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int STARVE_CNT_W = cnt_width(DEF_STARVE_LIMIT);
  localparam int WDOG_CNT_W   = cnt_width(DEF_TIMEOUT_CYCLES);

endpackage

// File: rtl/memory_arbiter_if.sv
// Requester and memory handshake signals of the arbiter.
// slave = arbiter view, master = requesters plus memory.
interface memory_arbiter_if #(
  parameter int WIDTH = 32
) ();

  logic             IReq;
  logic [WIDTH-1:0] IAddr;
  logic             IAck;
  logic [WIDTH-1:0] IRData;

  logic             DReq;
  logic             DWrite;
  logic [WIDTH-1:0] DAddr;
  logic [WIDTH-1:0] DWData;
  logic             DAck;
  logic [WIDTH-1:0] DRData;

  logic [WIDTH-1:0] MemAddr;
  logic             MemReadEnable;
  logic             MemWriteEnable;
  logic [WIDTH-1:0] MemWData;
  logic             MemAck;
  logic [WIDTH-1:0] MemRData;

  modport slave (
    input  IReq, IAddr, DReq, DWrite, DAddr, DWData, MemAck, MemRData,
    output IAck, IRData, DAck, DRData, MemAddr, MemReadEnable, MemWriteEnable, MemWData
  );

  modport master (
    output IReq, IAddr, DReq, DWrite, DAddr, DWData, MemAck, MemRData,
    input  IAck, IRData, DAck, DRData, MemAddr, MemReadEnable, MemWriteEnable, MemWData
  );

endinterface

// File: rtl/memory_arbiter_select.sv
// Grant decision: D has priority unless I has been passed over
// STARVE_LIMIT times in a row while waiting.
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int SW           = STARVE_CNT_W
) (
  input  logic          i_req,
  input  logic          d_req,
  input  logic [SW-1:0] starve_cnt,
  output grant_t        grant,
  output logic [SW-1:0] starve_next
);

  logic starved;

  assign starved = (starve_cnt >= SW'(STARVE_LIMIT));

  // Pick winner and the starve count that goes with that grant.
  always_comb begin
    grant       = GNT_NONE;
    starve_next = starve_cnt;
    if (d_req && !(i_req && starved)) begin
      grant = GNT_D;
      if (i_req) begin
        starve_next = starved ? SW'(STARVE_LIMIT) : starve_cnt + 1'b1;
      end else begin
        starve_next = '0;
      end
    end else if (i_req) begin
      grant       = GNT_I;
      starve_next = '0;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-ported memory between fetch (I) and load/store (D).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | sample requests, latch the winner's address/data/direction
// ISSUE | one-cycle read or write strobe to memory, watchdog cleared
// WAIT  | wait for MemAck; watchdog counts, fires at TIMEOUT_CYCLES
// RESP  | winner's Ack high for this cycle only
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int STARVE_LIMIT   = DEF_STARVE_LIMIT,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  memory_arbiter_if.slave        bus,
  output logic                   Busy,
  output logic                   Timeout
);

  // Package widths act as a floor so default builds match the package.
  localparam int SW = (cnt_width(STARVE_LIMIT) > STARVE_CNT_W) ?
                      cnt_width(STARVE_LIMIT) : STARVE_CNT_W;
  localparam int WW = (cnt_width(TIMEOUT_CYCLES) > WDOG_CNT_W) ?
                      cnt_width(TIMEOUT_CYCLES) : WDOG_CNT_W;

  state_t            state_q, state_d;
  grant_t            grant_q, grant_d;
  grant_t            sel_grant;
  logic [SW-1:0]     starve_q, starve_d, sel_starve;
  logic [WW-1:0]     wdog_q, wdog_d, wdog_inc;
  logic [WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic              write_q, write_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic              iack_q, iack_d;
  logic              dack_q, dack_d;
  logic [WIDTH-1:0]  irdata_q, irdata_d;
  logic [WIDTH-1:0]  drdata_q, drdata_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;

  mem_arb_select #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .SW           (SW)
  ) u_select (
    .i_req        (bus.IReq),
    .d_req        (bus.DReq),
    .starve_cnt   (starve_q),
    .grant        (sel_grant),
    .starve_next  (sel_starve)
  );

  assign wdog_inc = wdog_q + 1'b1;

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    starve_d    = starve_q;
    wdog_d      = wdog_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    write_d     = write_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    iack_d      = 1'b0;
    dack_d      = 1'b0;
    irdata_d    = irdata_q;
    drdata_d    = drdata_q;
    timeout_d   = timeout_q;

    unique case (state_q)
      IDLE: begin
        if (sel_grant != GNT_NONE) begin
          grant_d  = sel_grant;
          starve_d = sel_starve;
          state_d  = ISSUE;
          if (sel_grant == GNT_D) begin
            mem_addr_d  = bus.DAddr;
            mem_wdata_d = bus.DWData;
            write_d     = bus.DWrite;
            mem_re_d    = !bus.DWrite;
            mem_we_d    = bus.DWrite;
          end else begin
            mem_addr_d = bus.IAddr;
            write_d    = 1'b0;
            mem_re_d   = 1'b1;
          end
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wdog_d = wdog_inc;
        // A MemAck in the expiry cycle still counts as a normal completion.
        if (bus.MemAck) begin
          state_d = RESP;
          if (grant_q == GNT_I) begin
            iack_d   = 1'b1;
            irdata_d = bus.MemRData;
          end else begin
            dack_d = 1'b1;
            if (!write_q) drdata_d = bus.MemRData;
          end
        end else if (wdog_inc == WW'(TIMEOUT_CYCLES)) begin
          state_d   = RESP;
          timeout_d = 1'b1;
          if (grant_q == GNT_I) begin
            iack_d   = 1'b1;
            irdata_d = '0;
          end else begin
            dack_d   = 1'b1;
            drdata_d = '0;
          end
        end
      end
      RESP: begin
        grant_d = GNT_NONE;
        state_d = IDLE;
      end
      default: begin
        grant_d = GNT_NONE;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      grant_q     <= GNT_NONE;
      starve_q    <= '0;
      wdog_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      write_q     <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      iack_q      <= 1'b0;
      dack_q      <= 1'b0;
      irdata_q    <= '0;
      drdata_q    <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      starve_q    <= starve_d;
      wdog_q      <= wdog_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      write_q     <= write_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      iack_q      <= iack_d;
      dack_q      <= dack_d;
      irdata_q    <= irdata_d;
      drdata_q    <= drdata_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.MemAddr        = mem_addr_q;
  assign bus.MemWData       = mem_wdata_q;
  assign bus.MemReadEnable  = mem_re_q;
  assign bus.MemWriteEnable = mem_we_q;
  assign bus.IAck           = iack_q;
  assign bus.IRData         = irdata_q;
  assign bus.DAck           = dack_q;
  assign bus.DRData         = drdata_q;
  assign Busy               = busy_q;
  assign Timeout            = timeout_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: fixed-latency memory responder plus
// a linear sequence of hand-timed steps.
module tb_memory_arbiter;

  logic CLK;
  logic RST_N;
  logic Busy;
  logic Timeout;

  logic        mem_auto;
  logic        late_ack;
  logic [31:0] mem_data;
  logic        strobe_seen;

  int vectors;
  int miscompares;

  memory_arbiter_if #(.WIDTH(32)) bus ();

  memory_arbiter #(
    .WIDTH          (32),
    .STARVE_LIMIT   (4),
    .TIMEOUT_CYCLES (15)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .bus     (bus),
    .Busy    (Busy),
    .Timeout (Timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory: acks one cycle after a strobe when mem_auto is set; late_ack
  // injects an ack on demand. Updates land 2 time units after the edge.
  initial begin
    bus.MemAck   = 1'b0;
    bus.MemRData = '0;
    strobe_seen  = 1'b0;
    forever begin
      @(posedge CLK);
      #2;
      bus.MemAck   = (mem_auto && strobe_seen) || late_ack;
      bus.MemRData = bus.MemAck ? mem_data : 32'h0;
      strobe_seen  = bus.MemReadEnable | bus.MemWriteEnable;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_time_limit: observed still running, expected finished");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;
    RST_N       = 1'b0;
    mem_auto    = 1'b1;
    late_ack    = 1'b0;
    mem_data    = 32'h0;
    bus.IReq    = 1'b0;
    bus.IAddr   = '0;
    bus.DReq    = 1'b0;
    bus.DWrite  = 1'b0;
    bus.DAddr   = '0;
    bus.DWData  = '0;

    repeat (2) tick();
    check("rst_iack",    32'(bus.IAck), 32'd0);
    check("rst_dack",    32'(bus.DAck), 32'd0);
    check("rst_irdata",  bus.IRData, 32'd0);
    check("rst_drdata",  bus.DRData, 32'd0);
    check("rst_memaddr", bus.MemAddr, 32'd0);
    check("rst_memwdata", bus.MemWData, 32'd0);
    check("rst_strobes", 32'({bus.MemReadEnable, bus.MemWriteEnable}), 32'd0);
    check("rst_busy",    32'(Busy), 32'd0);
    check("rst_timeout", 32'(Timeout), 32'd0);
    RST_N = 1'b1;
    tick();

    // Single I read
    bus.IReq  = 1'b1;
    bus.IAddr = 32'h08;
    mem_data  = 32'hDEADBEEF;
    tick();
    check("t1_re_c1",   32'(bus.MemReadEnable), 32'd1);
    check("t1_we_c1",   32'(bus.MemWriteEnable), 32'd0);
    check("t1_addr_c1", bus.MemAddr, 32'h08);
    check("t1_busy_c1", 32'(Busy), 32'd1);
    tick();
    check("t1_re_c2",   32'(bus.MemReadEnable), 32'd0);
    check("t1_iack_c2", 32'(bus.IAck), 32'd0);
    tick();
    check("t1_iack_c3", 32'(bus.IAck), 32'd1);
    check("t1_irdata",  bus.IRData, 32'hDEADBEEF);
    check("t1_dack_c3", 32'(bus.DAck), 32'd0);
    tick();
    bus.IReq = 1'b0;
    check("t1_iack_c4", 32'(bus.IAck), 32'd0);
    check("t1_busy_c4", 32'(Busy), 32'd0);
    tick();

    // Simultaneous requests: D first, then I
    bus.IReq   = 1'b1;
    bus.IAddr  = 32'h100;
    bus.DReq   = 1'b1;
    bus.DWrite = 1'b0;
    bus.DAddr  = 32'h200;
    mem_data   = 32'hA5A50001;
    tick();
    check("t2_d_addr", bus.MemAddr, 32'h200);
    check("t2_d_re",   32'(bus.MemReadEnable), 32'd1);
    tick();
    tick();
    check("t2_dack",   32'(bus.DAck), 32'd1);
    check("t2_drdata", bus.DRData, 32'hA5A50001);
    check("t2_iack_early", 32'(bus.IAck), 32'd0);
    tick();
    bus.DReq = 1'b0;
    mem_data = 32'h0B0B0002;
    tick();
    check("t2_i_addr", bus.MemAddr, 32'h100);
    check("t2_i_re",   32'(bus.MemReadEnable), 32'd1);
    tick();
    tick();
    check("t2_iack",   32'(bus.IAck), 32'd1);
    check("t2_irdata", bus.IRData, 32'h0B0B0002);
    tick();
    bus.IReq = 1'b0;
    tick();

    // Starvation: four D grants, then I is forced
    bus.DReq   = 1'b1;
    bus.DWrite = 1'b0;
    bus.DAddr  = 32'h40;
    bus.IReq   = 1'b1;
    bus.IAddr  = 32'h80;
    mem_data   = 32'hC0FFEE00;
    for (int g = 0; g < 5; g++) begin
      tick();
      check($sformatf("t3_addr_g%0d", g), bus.MemAddr, (g < 4) ? 32'h40 : 32'h80);
      tick();
      tick();
      check($sformatf("t3_dack_g%0d", g), 32'(bus.DAck), (g < 4) ? 32'd1 : 32'd0);
      check($sformatf("t3_iack_g%0d", g), 32'(bus.IAck), (g < 4) ? 32'd0 : 32'd1);
      tick();
    end
    // Counter was cleared by the I grant, so D wins again
    bus.IAddr = 32'h84;
    tick();
    check("t3_after_clear_addr", bus.MemAddr, 32'h40);
    tick();
    tick();
    check("t3_after_clear_dack", 32'(bus.DAck), 32'd1);
    tick();
    bus.DReq = 1'b0;
    tick();
    check("t3_i2_addr", bus.MemAddr, 32'h84);
    tick();
    tick();
    check("t3_i2_iack", 32'(bus.IAck), 32'd1);
    check("t3_i2_irdata", bus.IRData, 32'hC0FFEE00);
    tick();
    bus.IReq = 1'b0;
    tick();

    // D write
    bus.DReq   = 1'b1;
    bus.DWrite = 1'b1;
    bus.DAddr  = 32'h10;
    bus.DWData = 32'h12345678;
    mem_data   = 32'h99999999;
    tick();
    bus.DWData = 32'hFFFFFFFF;
    check("t4_we_c1",    32'(bus.MemWriteEnable), 32'd1);
    check("t4_re_c1",    32'(bus.MemReadEnable), 32'd0);
    check("t4_wdata_c1", bus.MemWData, 32'h12345678);
    check("t4_addr_c1",  bus.MemAddr, 32'h10);
    tick();
    check("t4_we_c2",    32'(bus.MemWriteEnable), 32'd0);
    tick();
    check("t4_dack_c3",  32'(bus.DAck), 32'd1);
    check("t4_drdata_kept", bus.DRData, 32'hC0FFEE00);
    tick();
    bus.DReq   = 1'b0;
    bus.DWrite = 1'b0;
    check("t4_dack_c4",  32'(bus.DAck), 32'd0);
    tick();

    // MemAck in the same cycle the watchdog expires completes normally
    mem_auto  = 1'b0;
    bus.DReq  = 1'b1;
    bus.DAddr = 32'h20;
    mem_data  = 32'h0DDBA110;
    repeat (16) tick();
    check("t5a_dack_c16",    32'(bus.DAck), 32'd0);
    check("t5a_busy_c16",    32'(Busy), 32'd1);
    check("t5a_timeout_c16", 32'(Timeout), 32'd0);
    late_ack = 1'b1;
    tick();
    late_ack = 1'b0;
    check("t5a_dack_c17",    32'(bus.DAck), 32'd1);
    check("t5a_drdata",      bus.DRData, 32'h0DDBA110);
    check("t5a_timeout_c17", 32'(Timeout), 32'd0);
    tick();
    bus.DReq = 1'b0;
    tick();

    // Timeout: memory never acks
    bus.DReq  = 1'b1;
    bus.DAddr = 32'h24;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.DAck && n < 40);
    check("t5_ack_latency", 32'(n), 32'd17);
    check("t5_dack",    32'(bus.DAck), 32'd1);
    check("t5_drdata",  bus.DRData, 32'd0);
    check("t5_timeout", 32'(Timeout), 32'd1);
    tick();
    bus.DReq = 1'b0;
    late_ack = 1'b1;
    tick();
    late_ack = 1'b0;
    check("t5_late_busy",   32'(Busy), 32'd0);
    check("t5_late_acks",   32'({bus.IAck, bus.DAck}), 32'd0);
    check("t5_late_re",     32'(bus.MemReadEnable), 32'd0);
    check("t5_sticky",      32'(Timeout), 32'd1);
    mem_auto  = 1'b1;
    bus.IReq  = 1'b1;
    bus.IAddr = 32'h0C;
    mem_data  = 32'h13579BDF;
    tick();
    check("t5_i_re",   32'(bus.MemReadEnable), 32'd1);
    check("t5_i_addr", bus.MemAddr, 32'h0C);
    tick();
    tick();
    check("t5_i_iack",   32'(bus.IAck), 32'd1);
    check("t5_i_irdata", bus.IRData, 32'h13579BDF);
    check("t5_i_sticky", 32'(Timeout), 32'd1);
    tick();
    bus.IReq = 1'b0;
    tick();

    // Reset during WAIT
    mem_auto  = 1'b0;
    bus.DReq  = 1'b1;
    bus.DAddr = 32'h30;
    mem_data  = 32'h2468ACE0;
    tick();
    tick();
    RST_N = 1'b0;
    #1;
    check("t6_rst_busy",    32'(Busy), 32'd0);
    check("t6_rst_timeout", 32'(Timeout), 32'd0);
    check("t6_rst_memaddr", bus.MemAddr, 32'd0);
    check("t6_rst_irdata",  bus.IRData, 32'd0);
    check("t6_rst_drdata",  bus.DRData, 32'd0);
    check("t6_rst_strobes", 32'({bus.MemReadEnable, bus.MemWriteEnable}), 32'd0);
    check("t6_rst_acks",    32'({bus.IAck, bus.DAck}), 32'd0);
    tick();
    RST_N    = 1'b1;
    bus.DReq = 1'b0;
    late_ack = 1'b1;
    tick();
    late_ack = 1'b0;
    check("t6_post_dack1", 32'(bus.DAck), 32'd0);
    check("t6_post_busy1", 32'(Busy), 32'd0);
    tick();
    check("t6_post_dack2", 32'(bus.DAck), 32'd0);
    check("t6_post_busy2", 32'(Busy), 32'd0);
    mem_auto  = 1'b1;
    bus.DReq  = 1'b1;
    bus.DAddr = 32'h30;
    tick();
    check("t6_reissue_addr", bus.MemAddr, 32'h30);
    tick();
    tick();
    check("t6_reissue_dack",   32'(bus.DAck), 32'd1);
    check("t6_reissue_drdata", bus.DRData, 32'h2468ACE0);
    tick();
    bus.DReq = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares one single-ported memory between the instruction-fetch requester (I) and the load/store requester (D).
- The memory uses an enable/Ack handshake: enable sampled on CLK, Ack high for one cycle on the next edge, read data valid with Ack.
- Grants one transaction at a time, with D priority and a starvation guard for I, and returns registered data and Ack to the winner.
- A watchdog flags a memory that never acks.

Parameters:
- WIDTH, 32, data/address width in bits.
- STARVE_LIMIT, 4, consecutive D grants allowed while IReq is pending before I is forced.
- TIMEOUT_CYCLES, 15, cycles in WAIT without MemAck before the watchdog fires.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IReq  in  1  fetch request, held until IAck.
- IAddr  in  WIDTH  fetch byte address.
- IAck  out  1  one-cycle fetch completion pulse.
- IRData  out  WIDTH  fetched word, valid with IAck.
- DReq  in  1  data request, held until DAck.
- DWrite  in  1  1 = write, 0 = read.
- DAddr  in  WIDTH  data byte address.
- DWData  in  WIDTH  write data.
- DAck  out  1  one-cycle data completion pulse.
- DRData  out  WIDTH  read data, valid with DAck on reads.
- MemAddr  out  WIDTH  address to memory.
- MemReadEnable  out  1  one-cycle read strobe.
- MemWriteEnable  out  1  one-cycle write strobe.
- MemWData  out  WIDTH  write data to memory.
- MemAck  in  1  memory completion.
- MemRData  in  WIDTH  memory read data.
- Busy  out  1  high whenever state is not IDLE.
- Timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, RST_N=0):
  - State is IDLE, grant is NONE, starve and watchdog counters are 0.
  - All outputs are 0, including IRData/DRData/MemAddr/MemWData.
  - Reset mid-transaction abandons it; no Ack is ever produced for it.
- All outputs are registered. States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Requests are sampled. If none, stay in IDLE.
  - Otherwise pick a winner, latch its addr/wdata/write into the Mem* registers, and go to ISSUE.
- Grant rule:
  - Only DReq: grant D.
  - Only IReq: grant I.
  - Both: grant D unless starve count = STARVE_LIMIT, in which case grant I.
- Starve counter:
  - +1 on each D grant while IReq is high, saturating at STARVE_LIMIT.
  - Cleared on any I grant, and on a D grant with IReq low.
- ISSUE:
  - Exactly one of MemReadEnable/MemWriteEnable is high for this single cycle. I grants are always reads.
  - Go to WAIT. The watchdog counter is cleared.
- WAIT:
  - Strobes are 0. The watchdog counter increments each cycle.
  - On MemAck: capture MemRData into the winner's RData (reads only; DRData is unchanged on writes), pulse the winner's Ack in the next cycle, and go to RESP.
  - If the counter reaches TIMEOUT_CYCLES without MemAck: set Timeout, pulse the winner's Ack with RData = 0, and go to RESP.
- RESP: the Ack is high for exactly this cycle, then go to IDLE.
- Latency: request sampled in IDLE at cycle 0 → strobe in cycle 1 → MemAck in cycle 2 → Ack in cycle 3.
  - Throughput is one transaction per 4 cycles.
- Requester rule: Req is dropped or changed in the cycle after Ack. IDLE follows RESP, so a held request is re-granted only if it is still high then; there are no stale re-grants.
- Addr/data changes while a request is not granted are allowed; only the values sampled in IDLE are used.
- Ignored inputs:
  - MemAck outside WAIT is ignored, including a late ack after reset or after a timeout.
  - A MemAck arriving in the same cycle the watchdog reaches TIMEOUT_CYCLES wins: this is a normal completion with no Timeout.
- Timeout is cleared only by reset.
- Addresses pass through unmodified as byte addresses; the memory divides them.

Decomposition:
- Package mem_arb_pkg holds:
  - state_t enum {IDLE, ISSUE, WAIT, RESP};
  - grant_t enum {GNT_NONE, GNT_I, GNT_D};
  - localparam widths for the starve and watchdog counters, derived with $clog2.
- Sub-module mem_arb_select (combinational): inputs IReq, DReq, starve count; outputs grant_t and the next starve count.

Test Plan:
- Single I read: IReq=1, IAddr=0x08; memory acks in the cycle after the strobe with 0xDEADBEEF → MemReadEnable high in cycle 1 only, IAck in cycle 3 with IRData=0xDEADBEEF, DAck stays 0.
- Simultaneous requests: IReq and DReq both high in the same IDLE cycle → D granted first, and the I transaction completes immediately afterwards.
- Starvation: DReq held continuously as D read at 0x40 with IReq=1 throughout, STARVE_LIMIT=4 → the 5th grant goes to I; the starve counter returns to 0.
- Write: DWrite=1, DAddr=0x10, DWData=0x12345678 → MemWriteEnable one cycle with MemWData=0x12345678, DAck in cycle 3, DRData unchanged.
- Timeout: memory never acks, D read → Timeout=1 after 15 WAIT cycles, DAck pulse with DRData=0; a later MemAck in IDLE is ignored; a following I read works normally.
- Reset mid-WAIT: RST_N low during WAIT → all outputs 0 immediately; after release the old request is not acked unless reissued.
